// File: rtl/alu_cmd_sequencer.sv
// Sequenced command front-end for the combinational ALU: latches a command, holds the ALU inputs
// for a settle window, captures result and flags, and returns them on a valid/ready port.
module alu_cmd_sequencer #(
    parameter int unsigned W          = 12,
    parameter int unsigned SETTLE_CYC = 1,
    parameter int unsigned CNT_W      = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [W-1:0]     cmd_opnd,
    input  logic             cmd_load,
    input  logic             cmd_wb,
    output logic [W-1:0]     alu_a,
    output logic [W-1:0]     alu_b,
    output logic [2:0]       alu_op,
    input  logic [W-1:0]     alu_z,
    input  logic             alu_cout,
    input  logic             alu_ov,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [W-1:0]     rsp_z,
    output logic [3:0]       rsp_flags,
    output logic [W-1:0]     acc,
    output logic             sticky_ov,
    output logic [CNT_W-1:0] cmd_count
);

    typedef enum logic [1:0] {StIdle, StExec, StCapt, StResp} state_e;

    state_e           state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [W-1:0]     alu_a_q, alu_a_d;
    logic [W-1:0]     alu_b_q, alu_b_d;
    logic [2:0]       alu_op_q, alu_op_d;
    logic             wb_q, wb_d;
    logic [W-1:0]     rsp_z_q, rsp_z_d;
    logic [3:0]       flags_q, flags_d;
    logic [W-1:0]     acc_q, acc_d;
    logic             sticky_q, sticky_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             arith;
    logic             flag_c;
    logic             flag_v;

    // Carry and overflow are only meaningful for add/sub (opcodes 6 and 7).
    assign arith  = (alu_op_q[2:1] == 2'b11);
    assign flag_c = arith & alu_cout;
    assign flag_v = arith & alu_ov;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        alu_a_d  = alu_a_q;
        alu_b_d  = alu_b_q;
        alu_op_d = alu_op_q;
        wb_d     = wb_q;
        rsp_z_d  = rsp_z_q;
        flags_d  = flags_q;
        acc_d    = acc_q;
        sticky_d = sticky_q;
        count_d  = count_q;
        unique case (state_q)
            StIdle: begin
                if (cmd_valid) begin
                    if (cmd_load) begin
                        acc_d   = cmd_opnd;
                        rsp_z_d = cmd_opnd;
                        flags_d = {1'b0, cmd_opnd[W-1], 1'b0, (cmd_opnd == '0)};
                        state_d = StResp;
                    end else begin
                        alu_a_d  = acc_q;
                        alu_b_d  = cmd_opnd;
                        alu_op_d = cmd_op;
                        wb_d     = cmd_wb;
                        cnt_d    = '0;
                        state_d  = StExec;
                    end
                end
            end
            StExec: begin
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == 4'(SETTLE_CYC - 1)) begin
                    state_d = StCapt;
                end
            end
            StCapt: begin
                rsp_z_d  = alu_z;
                flags_d  = {flag_c, alu_z[W-1], flag_v, (alu_z == '0)};
                sticky_d = sticky_q | flag_v;
                if (wb_q) begin
                    acc_d = alu_z;
                end
                state_d = StResp;
            end
            StResp: begin
                if (rsp_ready) begin
                    count_d = count_q + 1'b1;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            alu_a_q  <= '0;
            alu_b_q  <= '0;
            alu_op_q <= '0;
            wb_q     <= 1'b0;
            rsp_z_q  <= '0;
            flags_q  <= '0;
            acc_q    <= '0;
            sticky_q <= 1'b0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            alu_a_q  <= alu_a_d;
            alu_b_q  <= alu_b_d;
            alu_op_q <= alu_op_d;
            wb_q     <= wb_d;
            rsp_z_q  <= rsp_z_d;
            flags_q  <= flags_d;
            acc_q    <= acc_d;
            sticky_q <= sticky_d;
            count_q  <= count_d;
        end
    end

    assign cmd_ready = (state_q == StIdle);
    assign rsp_valid = (state_q == StResp);
    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign alu_op    = alu_op_q;
    assign rsp_z     = rsp_z_q;
    assign rsp_flags = flags_q;
    assign acc       = acc_q;
    assign sticky_ov = sticky_q;
    assign cmd_count = count_q;

endmodule
